// File: rtl/secuencia_generador_pkg.sv
// secuencia_generador_pkg: shared FSM encoding and counter-width helper
package secuencia_generador_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, FIN = 2'b10} state_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/secuencia_generador_if.sv
// secuencia_generador_if: start/pattern request in, serial stream and status out
interface secuencia_generador_if #(parameter int WIDTH = 8, parameter int REP_W = 4);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             w;
  logic             valid;
  logic             busy;
  logic             done;
  modport master(output start, pattern, reps, input w, valid, busy, done);
  modport slave(input start, pattern, reps, output w, valid, busy, done);
endinterface

// File: rtl/secuencia_generador_divisor_tick.sv
// divisor_tick: one tick every BIT_CYCLES enabled cycles, restartable with clr
module divisor_tick
  import secuencia_generador_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = cnt_w(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  logic [CW-1:0] cnt;
  assign tick = en && (cnt == LAST);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/secuencia_generador.sv
// secuencia_generador: latches a pattern and shifts it out MSB-first, repeated reps+1 times
module secuencia_generador
  import secuencia_generador_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int REP_W      = 4
) (
  input logic                 clk,
  input logic                 reset,
  secuencia_generador_if.slave bus
);
  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] MSB = BW'(WIDTH - 1);
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] pat_q;
  logic [BW-1:0]    bit_cnt;
  logic [REP_W-1:0] play_cnt;
  logic             tick;
  logic             last_bit;
  logic             last_play;
  divisor_tick #(.BIT_CYCLES(BIT_CYCLES)) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (state != SHIFT),
    .en   (state == SHIFT),
    .tick (tick)
  );
  assign last_bit  = bit_cnt == '0;
  assign last_play = play_cnt == '0;
  // sr holds only the bits still to come; the bit on w lives in bus.w
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      sr        <= '0;
      pat_q     <= '0;
      bit_cnt   <= '0;
      play_cnt  <= '0;
      bus.w     <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state     <= SHIFT;
          pat_q     <= bus.pattern;
          sr        <= bus.pattern << 1;
          play_cnt  <= bus.reps;
          bit_cnt   <= MSB;
          bus.w     <= bus.pattern[WIDTH-1];
          bus.valid <= 1'b1;
          bus.busy  <= 1'b1;
        end
        SHIFT: if (tick) begin
          if (!last_bit) begin
            sr      <= sr << 1;
            bit_cnt <= bit_cnt - 1'b1;
            bus.w   <= sr[WIDTH-1];
          end else if (!last_play) begin
            sr       <= pat_q << 1;
            bit_cnt  <= MSB;
            play_cnt <= play_cnt - 1'b1;
            bus.w    <= pat_q[WIDTH-1];
          end else begin
            state     <= FIN;
            bus.w     <= 1'b0;
            bus.valid <= 1'b0;
            bus.done  <= 1'b1;
          end
        end
        FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_secuencia_generador.sv
// tb_secuencia_generador: random and directed stimulus against a per-cycle stream model
module tb_secuencia_generador;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] reps;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // two DUTs side by side: one bit per cycle and three cycles per bit
  for (genvar g = 0; g < 2; g++) begin : m
    localparam int B = g ? 3 : 1;
    secuencia_generador_if #(.WIDTH(8), .REP_W(4)) bus ();
    assign bus.start   = start;
    assign bus.pattern = pattern;
    assign bus.reps    = reps;
    secuencia_generador #(.WIDTH(8), .BIT_CYCLES(B), .REP_W(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
    logic [3:0] q[$];
    logic [3:0] e;
    int busy_cnt = 0;
    int exp_len = 0;
    // queue entries are {w, valid, busy, done} for each upcoming cycle
    always @(posedge clk) begin
      if (!reset) begin
        q.delete();
        busy_cnt = 0;
      end else if (q.size() != 0) begin
        void'(q.pop_front());
      end else if (start) begin
        for (int p = 0; p <= int'(reps); p++)
          for (int i = 7; i >= 0; i--)
            for (int c = 0; c < B; c++) q.push_back({pattern[i], 3'b110});
        q.push_back(4'b0011);
        exp_len = (int'(reps) + 1) * 8 * B + 1;
      end
      #1;
      e = (q.size() != 0) ? q[0] : 4'b0000;
      check($sformatf("outs_B%0d", B), 32'({bus.w, bus.valid, bus.busy, bus.done}), 32'(e));
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        check($sformatf("busy_len_B%0d", B), 32'(busy_cnt), 32'(exp_len));
        busy_cnt = 0;
      end
    end
  end
  task automatic send(input logic [7:0] p, input logic [3:0] r, input int gap);
    @(negedge clk);
    pattern = p;
    reps    = r;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  initial begin
    reset   = 1'b0;
    start   = 1'b1;
    pattern = 8'h3C;
    reps    = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_b1", 32'({m[0].bus.w, m[0].bus.valid, m[0].bus.busy, m[0].bus.done}), 32'h0);
    check("rst_b3", 32'({m[1].bus.w, m[1].bus.valid, m[1].bus.busy, m[1].bus.done}), 32'h0);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send(8'b0110_1100, 4'd0, 40);
    send(8'hA5, 4'd2, 80);
    send(8'h0F, 4'd0, 4);
    pattern = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      pattern = 8'($urandom);
      reps    = 4'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 15; i++) send(8'($urandom), 4'($urandom_range(0, 3)), 100);
    send(8'h81, 4'd15, 400);
    send(8'hB6, 4'd1, 3);
    #2 reset = 1'b0;
    #1;
    check("async_w_b1", 32'(m[0].bus.w), 32'h0);
    check("async_busy_b1", 32'(m[0].bus.busy), 32'h0);
    check("async_valid_b1", 32'(m[0].bus.valid), 32'h0);
    check("async_w_b3", 32'(m[1].bus.w), 32'h0);
    check("async_busy_b3", 32'(m[1].bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst_b1", 32'(m[0].bus.busy), 32'h0);
    check("idle_after_rst_b3", 32'(m[1].bus.busy), 32'h0);
    send(8'h5A, 4'd0, 30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
